// File: rtl/tph_bd_rx.sv
// Two-phase bundled-data receiver: synchronises req_t, captures ad into a
// first-word-fall-through FIFO and answers each accepted word with an ack_t toggle.
module tph_bd_rx #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 4
) (
   input  logic                     clk,
   input  logic                     _rst,
   input  logic                     req_t,
   input  logic [WIDTH-1:0]         ad,
   output logic                     ack_t,
   output logic [WIDTH-1:0]         m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     stall,
   output logic                     err,
   input  logic                     clr,
   output logic [1:0]               fsm_state
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      STALL  = 2'd2
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] req_sync;
   logic                   req_s;
   logic                   pending;
   logic                   full;
   logic                   do_write;
   logic                   do_read;
   logic                   req_moving;
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [WIDTH-1:0]       mem [DEPTH];

   assign req_s      = req_sync[SYNC_STAGES-1];
   assign pending    = req_s ^ ack_t;
   assign full       = (count == (AW+1)'(DEPTH));
   // The next stage differing from req_s means req_s changes on this edge.
   assign req_moving = req_sync[SYNC_STAGES-2] ^ req_s;

   // Writing also requires pending now, so a request withdrawn by a second
   // toggle (protocol error) never produces a spurious ack.
   assign do_write  = !clr && pending && (state != IDLE) && !full;
   assign do_read   = !clr && m_valid && m_ready;
   assign m_valid   = (count != '0);
   assign m_data    = m_valid ? mem[rd_ptr] : '0;
   assign fsm_state = state;

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         req_sync <= '0;
      end else begin
         req_sync <= {req_sync[SYNC_STAGES-2:0], req_t};
      end
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state  <= IDLE;
         ack_t  <= 1'b0;
         stall  <= 1'b0;
         err    <= 1'b0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         stall <= (state == STALL);

         // A write retires the request; otherwise classify from pre-edge values.
         if (do_write) begin
            ack_t <= ~ack_t;
            state <= IDLE;
         end else if (pending) begin
            state <= full ? STALL : ACCEPT;
         end else begin
            state <= IDLE;
         end

         if (clr) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
         end else begin
            if (do_write) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_read) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_write, do_read})
               2'b10:   count <= count + (AW+1)'(1);
               2'b01:   count <= count - (AW+1)'(1);
               default: count <= count;
            endcase
            if (pending && req_moving) begin
               err <= 1'b1;
            end
         end
      end
   end

   // Storage carries no reset; m_data is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= ad;
      end
   end

endmodule

// File: tb/tb_tph_bd_rx.sv
// Directed bench for tph_bd_rx: a cycle table for single words and overlap,
// then hand sequences for back-pressure, streaming, clr, protocol error and reset.
module tb_tph_bd_rx;

   localparam int WIDTH       = 8;
   localparam int SYNC_STAGES = 2;
   localparam int DEPTH       = 4;

   logic       clk     = 1'b0;
   logic       _rst    = 1'b0;
   logic       req_t   = 1'b0;
   logic [7:0] ad      = '0;
   logic       m_ready = 1'b0;
   logic       clr     = 1'b0;
   logic       ack_t;
   logic [7:0] m_data;
   logic       m_valid;
   logic [2:0] count;
   logic       stall;
   logic       err;
   logic [1:0] fsm_state;

   int         total   = 0;
   int         passed  = 0;
   logic [7:0] exp_q[$];
   logic       mon_en  = 1'b0;
   int         max_cnt = 0;

   tph_bd_rx #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      ._rst(_rst),
      .req_t(req_t),
      .ad(ad),
      .ack_t(ack_t),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .count(count),
      .stall(stall),
      .err(err),
      .clr(clr),
      .fsm_state(fsm_state)
   );

   // Clock / reset block: 10 ns period, reset is driven by the test sequence.
   always #5 clk = ~clk;

   typedef struct {
      logic       req;
      logic [7:0] ad;
      logic       rdy;
      logic       clr;
      logic       e_ack;
      logic       e_valid;
      logic [7:0] e_data;
      logic [2:0] e_count;
      logic       e_stall;
      logic       e_err;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(input logic req, input logic [7:0] d, input logic rdy,
                               input logic c, input logic eack, input logic ev,
                               input logic [7:0] ed, input logic [2:0] ec,
                               input logic est, input logic eer);
      vec_t v;
      v.req = req; v.ad = d; v.rdy = rdy; v.clr = c;
      v.e_ack = eack; v.e_valid = ev; v.e_data = ed; v.e_count = ec;
      v.e_stall = est; v.e_err = eer;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sender driver: hold ad, toggle req_t, wait a bounded time for the matching ack.
   task automatic send_word(input logic [7:0] d);
      int n;
      ad    = d;
      req_t = ~req_t;
      n     = 0;
      while (ack_t != req_t && n < 20) begin
         tick();
         n++;
      end
      check("ack_returned", 64'(ack_t), 64'(req_t));
   endtask

   // Scoreboard monitor: a pop happens at the next rising edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (int'(count) > max_cnt) max_cnt = int'(count);
         if (m_valid && m_ready && !clr) begin
            check("stream_expected_present", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               check("stream_order", 64'(m_data), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic ack_before;
      int   toggles;
      logic prev_ack;
      int   n;

      // Single word A5, second word 3C, then count=2 with a simultaneous write/read.
      vecs[0]  = mk(1, 8'hA5, 0, 0,  0, 0, 8'h00, 3'd0, 0, 0);
      vecs[1]  = mk(1, 8'hA5, 0, 0,  0, 0, 8'h00, 3'd0, 0, 0);
      vecs[2]  = mk(1, 8'hA5, 0, 0,  0, 0, 8'h00, 3'd0, 0, 0);
      vecs[3]  = mk(1, 8'hA5, 0, 0,  1, 1, 8'hA5, 3'd1, 0, 0);
      vecs[4]  = mk(1, 8'hA5, 1, 0,  1, 0, 8'h00, 3'd0, 0, 0);
      vecs[5]  = mk(0, 8'h3C, 0, 0,  1, 0, 8'h00, 3'd0, 0, 0);
      vecs[6]  = mk(0, 8'h3C, 0, 0,  1, 0, 8'h00, 3'd0, 0, 0);
      vecs[7]  = mk(0, 8'h3C, 0, 0,  1, 0, 8'h00, 3'd0, 0, 0);
      vecs[8]  = mk(0, 8'h3C, 0, 0,  0, 1, 8'h3C, 3'd1, 0, 0);
      vecs[9]  = mk(1, 8'h77, 0, 0,  0, 1, 8'h3C, 3'd1, 0, 0);
      vecs[10] = mk(1, 8'h77, 0, 0,  0, 1, 8'h3C, 3'd1, 0, 0);
      vecs[11] = mk(1, 8'h77, 0, 0,  0, 1, 8'h3C, 3'd1, 0, 0);
      vecs[12] = mk(1, 8'h77, 0, 0,  1, 1, 8'h3C, 3'd2, 0, 0);
      vecs[13] = mk(0, 8'h99, 0, 0,  1, 1, 8'h3C, 3'd2, 0, 0);
      vecs[14] = mk(0, 8'h99, 0, 0,  1, 1, 8'h3C, 3'd2, 0, 0);
      vecs[15] = mk(0, 8'h99, 0, 0,  1, 1, 8'h3C, 3'd2, 0, 0);
      vecs[16] = mk(0, 8'h99, 1, 0,  0, 1, 8'h77, 3'd2, 0, 0);
      vecs[17] = mk(0, 8'h99, 1, 0,  0, 1, 8'h99, 3'd1, 0, 0);
      vecs[18] = mk(0, 8'h99, 1, 0,  0, 0, 8'h00, 3'd0, 0, 0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 64'(ack_t), 64'd0);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_data", 64'(m_data), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      @(negedge clk);
      _rst = 1'b1;
      tick();

      // Cycle table
      for (int i = 0; i < 19; i++) begin
         req_t = vecs[i].req; ad = vecs[i].ad; m_ready = vecs[i].rdy; clr = vecs[i].clr;
         tick();
         check($sformatf("v%0d_ack", i), 64'(ack_t), 64'(vecs[i].e_ack));
         check($sformatf("v%0d_valid", i), 64'(m_valid), 64'(vecs[i].e_valid));
         check($sformatf("v%0d_data", i), 64'(m_data), 64'(vecs[i].e_data));
         check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_count));
         check($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
         check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
      end
      m_ready = 1'b0;
      tick();

      // Fill and back-pressure
      for (int k = 1; k <= 4; k++) send_word(8'(k));
      ad    = 8'd5;
      req_t = ~req_t;
      repeat (8) tick();
      check("fill_count", 64'(count), 64'd4);
      check("fill_stall", 64'(stall), 64'd1);
      check("fill_ack_frozen", 64'(ack_t), 64'd0);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("pop_count", 64'(count), 64'd3);
      check("pop_head", 64'(m_data), 64'd2);
      check("pop_no_ack_yet", 64'(ack_t), 64'd0);
      tick();
      check("late_write_ack", 64'(ack_t), 64'd1);
      check("late_write_count", 64'(count), 64'd4);
      tick();
      check("stall_released", 64'(stall), 64'd0);
      m_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         check($sformatf("drain_%0d", k), 64'(m_data), 64'(k));
         tick();
      end
      m_ready = 1'b0;
      check("drain_empty", 64'(count), 64'd0);

      // Streaming with wrap-around
      m_ready = 1'b1;
      max_cnt = 0;
      mon_en  = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         exp_q.push_back(8'(k));
         send_word(8'(k));
      end
      repeat (4) tick();
      mon_en  = 1'b0;
      m_ready = 1'b0;
      check("stream_all_drained", 64'(exp_q.size()), 64'd0);
      check("stream_max_count_le1", 64'(max_cnt <= 1), 64'd1);

      // clr held over a pending request: no write while clr, serviced afterwards
      ad    = 8'h5A;
      req_t = ~req_t;
      clr   = 1'b1;
      repeat (6) tick();
      check("clr_hold_ack", 64'(ack_t), 64'd1);
      check("clr_hold_count", 64'(count), 64'd0);
      clr = 1'b0;
      n = 0;
      while (ack_t != req_t && n < 10) begin
         tick();
         n++;
      end
      check("clr_then_ack", 64'(ack_t), 64'd0);
      check("clr_then_count", 64'(count), 64'd1);
      check("clr_then_data", 64'(m_data), 64'h5A);

      // Protocol error: two toggles before any ack
      send_word(8'h6B);
      ack_before = ack_t;
      req_t = ~req_t;
      tick();
      req_t = ~req_t;
      repeat (6) tick();
      check("perr_err", 64'(err), 64'd1);
      check("perr_ack_unchanged", 64'(ack_t), 64'(ack_before));
      check("perr_count", 64'(count), 64'd2);
      check("perr_head", 64'(m_data), 64'h5A);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("perr_clr_err", 64'(err), 64'd0);
      check("perr_clr_count", 64'(count), 64'd0);
      check("perr_clr_valid", 64'(m_valid), 64'd0);
      check("perr_clr_ack", 64'(ack_t), 64'(ack_before));

      // Reset mid-stall with req_t left at 1
      m_ready = 1'b1;
      send_word(8'h11);
      repeat (2) tick();
      m_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send_word(8'(k));
      ad    = 8'd5;
      req_t = 1'b1;
      repeat (8) tick();
      check("rstall_count", 64'(count), 64'd4);
      check("rstall_stall", 64'(stall), 64'd1);
      check("rstall_ack", 64'(ack_t), 64'd0);
      #2;
      _rst = 1'b0;
      #1;
      check("rst2_ack", 64'(ack_t), 64'd0);
      check("rst2_count", 64'(count), 64'd0);
      check("rst2_valid", 64'(m_valid), 64'd0);
      check("rst2_data", 64'(m_data), 64'd0);
      check("rst2_stall", 64'(stall), 64'd0);
      check("rst2_err", 64'(err), 64'd0);
      #3;
      _rst = 1'b1;
      toggles  = 0;
      prev_ack = ack_t;
      repeat (12) begin
         tick();
         if (ack_t != prev_ack) toggles++;
         prev_ack = ack_t;
      end
      check("rst2_one_toggle", 64'(toggles), 64'd1);
      check("rst2_ack_final", 64'(ack_t), 64'd1);
      check("rst2_count_final", 64'(count), 64'd1);
      check("rst2_data_final", 64'(m_data), 64'd5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tph_bd_rx.md
TPH_BD_RX -- requirements
Module: tph_bd_rx

Interface
REQ-001 Parameter WIDTH, default 8: bundled-data word width, legal range 1..64.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth on req_t, legal range 2..4.
REQ-003 Parameter DEPTH, default 4: receive FIFO depth, a power of two in the range 2..64.
REQ-004 Reset is _rst, asynchronous, active-low; the clock is clk.
REQ-005 clk  input  1  sole clock; every register is rising-edge triggered.
REQ-006 _rst  input  1  asynchronous active-low reset.
REQ-007 req_t  input  1  two-phase request from the sender; each level change announces one word; asynchronous to clk.
REQ-008 ad  input  WIDTH  bundled data; the sender holds it stable from before each req_t toggle until the matching ack_t toggle; it is not synchronised.
REQ-009 ack_t  output  1  two-phase acknowledge, registered.
REQ-010 m_data  output  WIDTH  head-of-FIFO word.
REQ-011 m_valid  output  1  FIFO not empty.
REQ-012 m_ready  input  1  consumer accepts m_data when m_valid and m_ready are both high at a rising edge.
REQ-013 count  output  clog2(DEPTH)+1  current FIFO occupancy, registered.
REQ-014 stall  output  1  registered; high while a request is pending and the FIFO is full.
REQ-015 err  output  1  sticky protocol-error flag, registered.
REQ-016 clr  input  1  synchronous flush of FIFO contents and err.

Function
REQ-017 req_t shall pass through SYNC_STAGES flops; req_s is the last stage; no other logic shall sample req_t.
REQ-018 pending shall equal req_s XOR ack_t.
REQ-019 FSM states: IDLE (pending=0), ACCEPT (pending=1 and count<DEPTH), STALL (pending=1 and count==DEPTH).
REQ-020 FSM state shall be evaluated from values held before each edge.
REQ-021 In ACCEPT, at the next edge: write ad into the FIFO tail, toggle ack_t, increment count (unless a read occurs in the same cycle).
REQ-022 Latency: ack_t toggles and m_valid can rise exactly SYNC_STAGES+1 edges after the first edge that samples the new req_t level.
REQ-023 At most one word shall be written per req_t toggle, and ack_t shall toggle exactly once per accepted word.
REQ-024 In STALL, ack_t shall hold and no write shall occur.
REQ-025 stall shall be 1 on the edge following entry to STALL and 0 on the edge following exit from STALL.
REQ-026 Back-pressure shall be lossless: the write occurs on the first edge on which count<DEPTH holds at evaluation.
REQ-027 A read freeing space in cycle n permits the write in cycle n+1; there is no same-cycle full bypass.
REQ-028 The FIFO shall be first-word-fall-through: m_data is valid whenever m_valid=1.
REQ-029 A read shall pop the head.
REQ-030 A simultaneous read and write shall leave count unchanged.
REQ-031 Read and write pointers shall be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-032 count shall never exceed DEPTH nor underflow.
REQ-033 m_ready while m_valid=0 shall be ignored.
REQ-034 Protocol error: if req_s changes while pending=1, set err=1 and keep it set until clr or reset.
REQ-035 After a protocol error, pending shall follow REQ-018 and no extra ack_t toggle shall be generated.
REQ-036 clr=1 at an edge shall set count=0, set the pointers to 0, set m_valid=0 and set err=0.
REQ-037 clr shall not change ack_t or the synchroniser.
REQ-038 With clr=1, any write and any read in that cycle shall be suppressed; a pending request is serviced after clr deasserts.

Reset
REQ-039 _rst=0 shall asynchronously force ack_t=0, all synchroniser stages=0, count=0, pointers=0, m_valid=0, m_data=0, stall=0 and err=0, and the FSM shall enter IDLE.
REQ-040 FIFO storage need not be reset; m_data shall read 0 while count=0.
REQ-041 Reset asserted mid-handshake discards buffered words; after release ack_t=0, and a sender holding req_t=1 is seen as pending and serviced once.

Verification
REQ-042 Single word: WIDTH=8, req_t 0->1 with ad=0xA5 -> ack_t 0->1 exactly SYNC_STAGES+1 edges after the first sampling edge; m_valid=1, m_data=0xA5, count=1 on that same edge.
REQ-043 Fill and back-pressure: DEPTH=4, m_ready=0, 5 handshakes with data 1..5 -> 4 acks; count=4; stall=1; ack_t frozen. Then m_ready=1 for one cycle -> data 1 popped; word 5 written the following edge; 5th ack follows.
REQ-044 Streaming wrap-around: 20 handshakes with m_ready=1 throughout -> output order 1..20, count never exceeds 1, pointers wrap without loss.
REQ-045 Simultaneous: count=2 while a write and a read occur on the same edge -> count stays 2 and ordering is preserved.
REQ-046 Protocol error: req_t toggled twice before ack_t responds -> err=1; clr pulse -> err=0, count=0, ack_t unchanged.
REQ-047 Reset mid-stall: count=4 and stall=1, then _rst pulse -> all outputs 0; with req_t still 1, exactly one ack_t toggle occurs after release.
